// File: rtl/grey_pkg.sv
// ---------------------------------------------------------------------------
// grey_pkg
// Definitions shared by the grey-scale serial transmitter and receiver.
//   - next_grey(): one step along the 2-bit Gray ring, in either direction
//   - register address constants for the transmitter and receiver maps
//   - receiver FSM state type
// No ports (package).
// ---------------------------------------------------------------------------
package grey_pkg;

    // Transmitter register map
    localparam logic [3:0] ADDR_CDIV  = 4'd0;
    localparam logic [3:0] ADDR_NBITS = 4'd4;
    localparam logic [3:0] ADDR_DATA  = 4'd8;
    localparam logic [3:0] ADDR_STAT  = 4'd12;

    // Receiver register map
    localparam logic [3:0] RX_ADDR_NBITS = 4'd0;
    localparam logic [3:0] RX_ADDR_DATA  = 4'd4;
    localparam logic [3:0] RX_ADDR_STAT  = 4'd8;
    localparam logic [3:0] RX_ADDR_TMO   = 4'd12;

    // Receiver FSM states
    typedef enum logic [1:0] {
        Sreset  = 2'd0,
        Sidle   = 2'd1,
        Srecv   = 2'd2,
        Scommit = 2'd3
    } rx_state_t;

    // Forward ring is 0 -> 1 -> 3 -> 2 -> 0; backward walks it the other way.
    function automatic logic [1:0] next_grey(input logic dir, input logic [1:0] cp);
        logic [1:0] np;
        np = 2'b00;
        if (dir) begin
            case (cp)
                2'b00:   np = 2'b01;
                2'b01:   np = 2'b11;
                2'b11:   np = 2'b10;
                default: np = 2'b00;
            endcase
        end else begin
            case (cp)
                2'b00:   np = 2'b10;
                2'b10:   np = 2'b11;
                2'b11:   np = 2'b01;
                default: np = 2'b00;
            endcase
        end
        return np;
    endfunction

endpackage

// File: rtl/grey_step_detect.sv
// ---------------------------------------------------------------------------
// grey_step_detect
// Synchronises the 2-bit Gray line and classifies every change against the
// last accepted position (ref).
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   i_ss       raw Gray line from the transmitter
//   o_step     a legal single-bit step is present this cycle
//   o_dir      1 = forward step (data 1), 0 = backward step (data 0);
//              only meaningful while o_step is high
//   o_illegal  both bits changed at once (0<->3 or 1<->2)
// ---------------------------------------------------------------------------
module grey_step_detect
    import grey_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_ss,
    output logic       o_step,
    output logic       o_dir,
    output logic       o_illegal
);

    // A one-flop synchroniser is not safe, so anything below 2 is raised to 2.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [1:0] r_sync [STAGES];
    logic [1:0] r_ref;
    logic [1:0] w_syncSs;
    logic [1:0] w_diff;

    assign w_syncSs = r_sync[STAGES-1];
    assign w_diff   = w_syncSs ^ r_ref;

    // Shift the line through the synchroniser chain. ref follows the
    // synchronised line on any change, legal or not, so after an illegal
    // jump the next frame is decoded relative to the new position.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= 2'b00;
            end
            r_ref <= 2'b00;
        end else begin
            r_sync[0] <= i_ss;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            if (w_syncSs != r_ref) begin
                r_ref <= w_syncSs;
            end
        end
    end

    // Exactly one bit different is a step; both bits different is a
    // violation of the Gray code.
    assign o_step    = w_diff[0] ^ w_diff[1];
    assign o_illegal = w_diff[0] & w_diff[1];
    assign o_dir     = (w_syncSs == next_grey(1'b1, r_ref));

endmodule

// File: rtl/grey_scale_rx.sv
// ---------------------------------------------------------------------------
// grey_scale_rx
// Receiver for the 2-bit Gray-step serial line. Forward steps are 1 bits,
// backward steps are 0 bits, LSB first; a frame is nbits+1 bits long.
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   ss       Gray-coded serial line from the transmitter
//   rw       1 = write addr this cycle, 0 = read
//   addr     register address: 0 nbits, 4 rx_data, 8 status, 12 timeout
//   datain   write data
//   dataout  combinational read data (0 during writes / unmapped addr)
//   irq      registered rx_valid | rx_error
// Status bits: [2] overrun, [1] rx_error, [0] rx_valid, write-1-to-clear.
// ---------------------------------------------------------------------------
module grey_scale_rx
    import grey_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ss,
    input  logic        rw,
    input  logic [3:0]  addr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        irq
);

    logic        w_step;
    logic        w_dir;
    logic        w_illegal;

    rx_state_t   r_state;
    rx_state_t   w_stateNxt;

    logic [3:0]  r_nbits;
    logic [31:0] r_timeout;
    logic [15:0] r_rxData;
    logic [2:0]  r_status;
    logic        r_irq;

    logic [3:0]  r_frameLen;
    logic [15:0] r_shreg;
    logic [4:0]  r_bcnt;
    logic [31:0] r_tcnt;
    logic        r_pend;
    logic        r_pendDir;

    logic [3:0]  w_frameLenNxt;
    logic [15:0] w_shregNxt;
    logic [4:0]  w_bcntNxt;
    logic [31:0] w_tcntNxt;
    logic        w_pendNxt;
    logic        w_pendDirNxt;

    logic        w_evStep;
    logic        w_evDir;
    logic        w_extra;
    logic [31:0] w_tcntInc;
    logic        w_commit;
    logic        w_setValid;
    logic        w_setError;
    logic        w_setOverrun;
    logic [2:0]  w_clr;
    logic [2:0]  w_statusNxt;
    logic        w_wrNbits;
    logic        w_wrTmo;

    grey_step_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_stepDetect (
        .clk       (clk),
        .reset     (reset),
        .i_ss      (ss),
        .o_step    (w_step),
        .o_dir     (w_dir),
        .o_illegal (w_illegal)
    );

    // A step held over from the commit cycle is consumed before a live one.
    // If both are present, the live step is parked in the pending slot so
    // the pair is absorbed one cycle late instead of being dropped.
    assign w_evStep  = r_pend | w_step;
    assign w_evDir   = r_pend ? r_pendDir : w_dir;
    assign w_extra   = r_pend & w_step;
    assign w_tcntInc = (r_tcnt == 32'hFFFF_FFFF) ? r_tcnt : r_tcnt + 32'd1;

    // Next-state and datapath decisions for the frame assembler.
    always_comb begin
        w_stateNxt    = r_state;
        w_frameLenNxt = r_frameLen;
        w_shregNxt    = r_shreg;
        w_bcntNxt     = r_bcnt;
        w_tcntNxt     = r_tcnt;
        w_pendNxt     = r_pend;
        w_pendDirNxt  = r_pendDir;
        w_commit      = 1'b0;
        w_setError    = 1'b0;

        case (r_state)
            Sreset: begin
                w_stateNxt = Sidle;
                if (w_illegal) begin
                    w_setError = 1'b1;
                end
                if (w_step) begin
                    w_pendNxt    = 1'b1;
                    w_pendDirNxt = w_dir;
                end
            end

            Sidle: begin
                if (w_illegal) begin
                    w_setError = 1'b1;
                    w_pendNxt  = 1'b0;
                end else if (w_evStep) begin
                    w_frameLenNxt = r_nbits;
                    w_shregNxt    = {15'd0, w_evDir};
                    w_bcntNxt     = 5'd1;
                    w_tcntNxt     = 32'd0;
                    w_pendNxt     = w_extra;
                    w_pendDirNxt  = w_dir;
                    w_stateNxt    = (r_nbits == 4'd0) ? Scommit : Srecv;
                end
            end

            Srecv: begin
                if (w_illegal) begin
                    w_setError = 1'b1;
                    w_pendNxt  = 1'b0;
                    w_stateNxt = Sidle;
                end else if (w_evStep) begin
                    w_shregNxt[r_bcnt[3:0]] = w_evDir;
                    w_bcntNxt    = r_bcnt + 5'd1;
                    w_tcntNxt    = 32'd0;
                    w_pendNxt    = w_extra;
                    w_pendDirNxt = w_dir;
                    if (r_bcnt == {1'b0, r_frameLen}) begin
                        w_stateNxt = Scommit;
                    end
                end else begin
                    w_tcntNxt = w_tcntInc;
                    if ((r_timeout != 32'd0) && (w_tcntInc >= r_timeout)) begin
                        w_setError = 1'b1;
                        w_stateNxt = Sidle;
                    end
                end
            end

            Scommit: begin
                w_commit   = 1'b1;
                w_stateNxt = Sidle;
                if (w_illegal) begin
                    w_setError = 1'b1;
                end
                if (w_step && !r_pend) begin
                    w_pendNxt    = 1'b1;
                    w_pendDirNxt = w_dir;
                end
            end

            default: begin
                w_stateNxt = Sidle;
            end
        endcase
    end

    // Status update: hardware sets are OR-ed in after the W1C clear so a
    // set in the same cycle as a clear of that bit wins.
    assign w_setValid   = w_commit;
    assign w_setOverrun = w_commit & r_status[0];
    assign w_clr        = (rw && (addr == RX_ADDR_STAT)) ? datain[2:0] : 3'b000;
    assign w_statusNxt  = (r_status & ~w_clr) | {w_setOverrun, w_setError, w_setValid};
    assign w_wrNbits    = rw && (addr == RX_ADDR_NBITS);
    assign w_wrTmo      = rw && (addr == RX_ADDR_TMO);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= Sreset;
        end else begin
            r_state <= w_stateNxt;
        end
    end

    // Frame datapath, host registers and irq. irq is driven from the next
    // status value so it lines up with the status register itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frameLen <= 4'd0;
            r_shreg    <= 16'd0;
            r_bcnt     <= 5'd0;
            r_tcnt     <= 32'd0;
            r_pend     <= 1'b0;
            r_pendDir  <= 1'b0;
            r_nbits    <= 4'd0;
            r_timeout  <= 32'd0;
            r_rxData   <= 16'd0;
            r_status   <= 3'b000;
            r_irq      <= 1'b0;
        end else begin
            r_frameLen <= w_frameLenNxt;
            r_shreg    <= w_shregNxt;
            r_bcnt     <= w_bcntNxt;
            r_tcnt     <= w_tcntNxt;
            r_pend     <= w_pendNxt;
            r_pendDir  <= w_pendDirNxt;
            if (w_wrNbits) begin
                r_nbits <= datain[3:0];
            end
            if (w_wrTmo) begin
                r_timeout <= datain;
            end
            if (w_commit) begin
                r_rxData <= r_shreg;
            end
            r_status <= w_statusNxt;
            r_irq    <= w_statusNxt[0] | w_statusNxt[1];
        end
    end

    assign irq = r_irq;

    // Read mux; writes and unmapped addresses read as zero.
    always_comb begin
        dataout = 32'd0;
        if (!rw) begin
            case (addr)
                RX_ADDR_NBITS: dataout = {28'd0, r_nbits};
                RX_ADDR_DATA:  dataout = {16'd0, r_rxData};
                RX_ADDR_STAT:  dataout = {29'd0, r_status};
                RX_ADDR_TMO:   dataout = r_timeout;
                default:       dataout = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_grey_scale_rx.sv
// ---------------------------------------------------------------------------
// tb_grey_scale_rx
// Bench for grey_scale_rx: drives Gray-step frames on ss and keeps an
// abstract register-level model of what the receiver must show.
// ---------------------------------------------------------------------------
module tb_grey_scale_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ss;
    logic        rw;
    logic [3:0]  addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        irq;

    int nTests = 0;
    int nFail  = 0;

    logic [3:0]  mNbits;
    logic [15:0] mData;
    logic [2:0]  mStatus;
    logic [31:0] mTimeout;
    bit          modelValid = 1'b0;
    logic [1:0]  pos;
    int          rotIdx = 0;

    logic [1:0] fwdTbl [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic [1:0] bwdTbl [4] = '{2'd2, 2'd0, 2'd3, 2'd1};

    grey_scale_rx #(
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ss      (ss),
        .rw      (rw),
        .addr    (addr),
        .datain  (datain),
        .dataout (dataout),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expRead(input logic [3:0] a);
        case (a)
            4'd0:    return {28'd0, mNbits};
            4'd4:    return {16'd0, mData};
            4'd8:    return {29'd0, mStatus};
            4'd12:   return mTimeout;
            default: return 32'd0;
        endcase
    endfunction

    // Model comparison on every settled cycle.
    always @(negedge clk) begin
        if (modelValid && !reset) begin
            checkOutput($sformatf("dataout rw=%0d addr=%0d", rw, addr), dataout,
                        rw ? 32'd0 : expRead(addr));
            checkOutput("irq", {31'd0, irq}, {31'd0, mStatus[0] | mStatus[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rotIdx++;
        addr = {rotIdx[1:0], 2'b00};
        rw   = 1'b0;
    endtask

    task automatic writeReg(input logic [3:0] a, input logic [31:0] d);
        rw     = 1'b1;
        addr   = a;
        datain = d;
        @(posedge clk);
        #1;
        case (a)
            4'd0:    mNbits   = d[3:0];
            4'd8:    mStatus  = mStatus & ~d[2:0];
            4'd12:   mTimeout = d;
            default: ;
        endcase
        rw     = 1'b0;
        datain = 32'd0;
    endtask

    task automatic readReg(input logic [3:0] a, output logic [31:0] got);
        rw   = 1'b0;
        addr = a;
        @(negedge clk);
        got = dataout;
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input int hold);
        ss  = v;
        pos = v;
        repeat (hold) tick();
    endtask

    task automatic sendWord(input logic [15:0] word, input int nb, input int hold);
        for (int i = 0; i < nb; i++) begin
            applyStimulus(word[i] ? fwdTbl[pos] : bwdTbl[pos], hold);
        end
    endtask

    task automatic settle();
        repeat (6) tick();
    endtask

    task automatic modelCommit(input logic [15:0] word);
        logic [16:0] m;
        m = (17'd1 << (mNbits + 5'd1)) - 17'd1;
        mData = word & m[15:0];
        if (mStatus[0]) begin
            mStatus[2] = 1'b1;
        end
        mStatus[0] = 1'b1;
    endtask

    task automatic modelReset();
        mNbits   = 4'd0;
        mData    = 16'd0;
        mStatus  = 3'b000;
        mTimeout = 32'd0;
    endtask

    initial begin
        #2000000;
        nFail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  seq [8] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};

        reset  = 1'b1;
        ss     = 2'd0;
        pos    = 2'd0;
        rw     = 1'b0;
        addr   = 4'd0;
        datain = 32'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        modelValid = 1'b1;

        // Reset values
        readReg(4'd0, rd);  checkOutput("reset nbits", rd, 32'd0);
        readReg(4'd4, rd);  checkOutput("reset rx_data", rd, 32'd0);
        readReg(4'd8, rd);  checkOutput("reset status", rd, 32'd0);
        readReg(4'd12, rd); checkOutput("reset timeout", rd, 32'd0);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);

        // 8-bit frame from a literal ss sequence, 0xA5
        writeReg(4'd0, 32'd7);
        readReg(4'd0, rd); checkOutput("nbits readback", rd, 32'd7);
        modelValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(seq[i], 4);
        end
        readReg(4'd8, rd); checkOutput("status 4 clocks after last step", rd, 32'h1);
        readReg(4'd4, rd); checkOutput("rx_data A5", rd, 32'h00A5);
        checkOutput("irq after A5", {31'd0, irq}, 32'd1);
        modelCommit(16'h00A5);
        modelValid = 1'b1;
        settle();

        // W1C of rx_valid, then a 1-bit frame
        writeReg(4'd8, 32'h1);
        readReg(4'd8, rd); checkOutput("status after W1C", rd, 32'h0);
        checkOutput("irq after W1C", {31'd0, irq}, 32'd0);
        writeReg(4'd0, 32'd0);
        modelValid = 1'b0;
        sendWord(16'h0000, 1, 4);
        settle();
        modelCommit(16'h0000);
        modelValid = 1'b1;
        readReg(4'd4, rd); checkOutput("rx_data 1-bit frame", rd, 32'h0);
        readReg(4'd8, rd); checkOutput("status 1-bit frame", rd, 32'h1);

        // Back-to-back frames one step per clock, no clear in between
        writeReg(4'd8, 32'h7);
        writeReg(4'd0, 32'd7);
        modelValid = 1'b0;
        sendWord(16'h003C, 8, 1);
        sendWord(16'h00FF, 8, 1);
        settle();
        modelCommit(16'h003C);
        modelCommit(16'h00FF);
        modelValid = 1'b1;
        readReg(4'd4, rd); checkOutput("rx_data back-to-back", rd, 32'h00FF);
        readReg(4'd8, rd); checkOutput("status overrun", rd, 32'h5);

        // Illegal jump after 3 bits
        writeReg(4'd8, 32'h7);
        modelValid = 1'b0;
        sendWord(16'h0005, 3, 4);
        applyStimulus(pos ^ 2'b11, 4);
        settle();
        mStatus[1] = 1'b1;
        modelValid = 1'b1;
        readReg(4'd8, rd); checkOutput("status illegal", rd, 32'h2);
        readReg(4'd4, rd); checkOutput("rx_data kept on illegal", rd, 32'h00FF);
        modelValid = 1'b0;
        sendWord(16'h005A, 8, 4);
        settle();
        modelCommit(16'h005A);
        modelValid = 1'b1;
        readReg(4'd4, rd); checkOutput("rx_data after illegal", rd, 32'h005A);
        readReg(4'd8, rd); checkOutput("status after illegal frame", rd, 32'h3);

        // Timeout on a stalled 16-bit frame, then a full 0xBEEF
        writeReg(4'd12, 32'd20);
        writeReg(4'd0, 32'd15);
        writeReg(4'd8, 32'h7);
        modelValid = 1'b0;
        sendWord(16'hBEEF, 5, 4);
        repeat (25) tick();
        mStatus[1] = 1'b1;
        modelValid = 1'b1;
        readReg(4'd8, rd); checkOutput("status timeout", rd, 32'h2);
        modelValid = 1'b0;
        sendWord(16'hBEEF, 16, 4);
        settle();
        modelCommit(16'hBEEF);
        modelValid = 1'b1;
        readReg(4'd4, rd); checkOutput("rx_data BEEF", rd, 32'hBEEF);
        readReg(4'd8, rd); checkOutput("status BEEF", rd, 32'h3);

        // Reset in the middle of a frame
        writeReg(4'd0, 32'd7);
        modelValid = 1'b0;
        sendWord(16'h0007, 3, 4);
        reset = 1'b1;
        ss    = 2'd0;
        pos   = 2'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        modelValid = 1'b1;
        readReg(4'd0, rd);  checkOutput("mid reset nbits", rd, 32'd0);
        readReg(4'd4, rd);  checkOutput("mid reset rx_data", rd, 32'd0);
        readReg(4'd8, rd);  checkOutput("mid reset status", rd, 32'd0);
        readReg(4'd12, rd); checkOutput("mid reset timeout", rd, 32'd0);
        checkOutput("mid reset irq", {31'd0, irq}, 32'd0);
        writeReg(4'd0, 32'd7);
        modelValid = 1'b0;
        sendWord(16'h0081, 8, 4);
        settle();
        modelCommit(16'h0081);
        modelValid = 1'b1;
        readReg(4'd4, rd); checkOutput("rx_data 81", rd, 32'h0081);
        readReg(4'd8, rd); checkOutput("status 81", rd, 32'h1);
        settle();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/grey_scale_rx.md
Name: grey_scale_rx

Overview:
- Receiver for the 2-bit Gray-step serial line driven by the existing grey-scale transmitter.
- Each single-bit Gray step on ss carries one data bit: a forward step (0→1→3→2→0) is a 1, a backward step is a 0, LSB first.
- Samples ss through a synchronizer, assembles a frame of nbits+1 bits, and presents the word and status through the same 0/4/8/12 register map style as the transmitter.
- Sits at the far end of the ss pair, typically in the peer device or in the loopback bench.

Parameters:
- SYNC_STAGES, 2, flops in the ss input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ss  input  2  Gray-coded serial line from transmitter
- rw  input  1  1 = write to addr this cycle, 0 = read
- addr  input  4  register address: 0, 4, 8 or 12
- datain  input  32  write data
- dataout  output  32  combinational read data, 0 during writes or for an unmapped addr
- irq  output  1  registered; equals rx_valid | rx_error

Behaviour:
Register map:
- 0: nbits[3:0], R/W, frame length coded n-1. Reset 0.
- 4: rx_data[15:0], read-only; writes ignored. Reset 0.
- 8: status {overrun, rx_error, rx_valid} in bits [2:0], read-only except write-1-to-clear per bit. Reset 0.
- 12: timeout[31:0], R/W. Idle-clock limit within a frame; 0 disables. Reset 0.

Input path:
- ss passes through SYNC_STAGES flops, giving sync_ss.
- ref holds the last accepted Gray position. Reset value 0, which matches the transmitter's reset value.
- Step valid when sync_ss != ref and the two differ in exactly 1 bit.
- dir = 1 if sync_ss == next_grey(forward, ref), else 0.
- On a valid step, ref <= sync_ss.
- Illegal step: sync_ss differs from ref in both bits (0<->3 or 1<->2). Then ref <= sync_ss, rx_error <= 1, the frame in progress is aborted (nothing committed), and the FSM goes to Sidle.

FSM states: Sreset, Sidle, Srecv, Scommit.
- Sreset → Sidle after 1 cycle.
- Sidle:
  - On a valid step: frame_len <= nbits (latched, so nbits writes mid-frame apply to the next frame), shreg <= 0, shreg[0] <= dir, bcnt <= 1, tcnt <= 0.
  - If frame_len == 0, go to Scommit; otherwise go to Srecv.
- Srecv:
  - On a valid step: shreg[bcnt] <= dir, bcnt <= bcnt+1, tcnt <= 0. If bcnt == frame_len, go to Scommit.
  - With no step: tcnt <= tcnt+1. If timeout != 0 and tcnt+1 >= timeout, set rx_error and go to Sidle (frame discarded).
- Scommit (1 cycle):
  - rx_data <= shreg; bits above frame_len are 0.
  - If rx_valid is already 1, set overrun; the new data overwrites.
  - Set rx_valid. Go to Sidle.
  - A step arriving in this cycle is not lost: ref still updates, and the step is processed as a new frame start on the next cycle. The FSM keeps a 1-entry pending step flag for this.

Counter widths:
- bcnt is 5 bits, so a 16-bit frame (nbits = 15) reaches bcnt = 16 without wrap.
- tcnt is 32 bits and saturates.

Latency:
- ss pin change to step detection: SYNC_STAGES+1 rising edges.
- Final step to rx_valid readable: SYNC_STAGES+2 edges, i.e. 4 with the default.

Simultaneous events:
- A W1C clear in the same cycle as a hardware set of the same bit: the set wins.
- A write to nbits or timeout during a frame: nbits takes effect at the next frame start; timeout takes effect immediately.

Reset:
- Reset asserted mid-frame returns every register, ref, the FSM state and irq to their reset values on that edge. The partial frame is discarded.
- irq resets to 0. dataout is combinational and has no reset value of its own.

Decomposition:
- Shared package grey_pkg holds:
  - next_grey(dir, cp) function, shared with the transmitter.
  - Register address constants ADDR_CDIV/NBITS = 0/4, ADDR_DATA = 8, ADDR_STAT = 12 for the transmitter. The receiver's own map uses RX_ADDR_NBITS = 0, RX_ADDR_DATA = 4, RX_ADDR_STAT = 8, RX_ADDR_TMO = 12.
  - rx FSM state typedef.
- One sub-module: grey_step_detect. It contains the synchronizer, ref, and the step/dir/illegal outputs.

Test Plan:
- nbits = 7; ss driven 1,0,1,0,2,0,2,0, each value held 4 clocks → rx_data = 0x00A5; status = 0x1 no later than 4 clocks after the last change; irq = 1.
- Write 0x1 to addr 8 after the previous test → status = 0. Send a 1-bit frame (nbits = 0), ss 0→2 → rx_data = 0x0000, rx_valid = 1.
- Two 8-bit frames back-to-back without clearing: 0x3C then 0xFF → rx_data = 0x00FF, status = 0x5 (overrun and valid).
- ss jumps 0→3 mid-frame after 3 bits → status bit1 = 1, rx_data unchanged. The next legal 8-bit frame from ref = 3 decodes correctly.
- timeout = 20, nbits = 15; 5 bits sent, then ss held for 25 clocks → rx_error = 1 and FSM returns to Sidle. A subsequent full 16-bit 0xBEEF frame is received as 0xBEEF.
- reset asserted mid-frame for 1 clock → all registers 0, irq = 0. A following 8-bit 0x81 frame is received correctly.
